hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised successor of the ID-stage load-use bubble logic for the five-stage pipeline.
- Detects RAW hazards between the instruction in ID and older instructions in EX/MEM.
- Generates PC/IF-ID stall, ID/EX bubble and IF/ID flush controls.
- Adds multi-cycle load stalls, x0 exclusion, per-source use flags, a no-forwarding mode, branch-flush priority and a saturating stall counter.

Parameters:
- REG_AW, 5: register-index width.
- LOAD_STALL, 1: bubbles inserted per load-use hazard; legal range 1..7.
- FWD_EN, 1: 1 = forwarding present, only load-use stalls; 0 = stall on any EX/MEM RAW.
- CNT_W, 16: stall_count width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- clear_n  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- id_rs1  input  REG_AW  ID source register 1.
- id_rs2  input  REG_AW  ID source register 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_is_load  input  1  EX instruction is a load (opcode 0000011).
- ex_reg_write  input  1  EX instruction writes rd.
- ex_rd  input  REG_AW  EX destination.
- mem_valid  input  1  MEM holds a real instruction.
- mem_reg_write  input  1  MEM instruction writes rd.
- mem_rd  input  REG_AW  MEM destination.
- branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- pc_stall  output  1  hold PC.
- ifid_stall  output  1  hold IF/ID register.
- idex_bubble  output  1  load a NOP into ID/EX.
- ifid_flush  output  1  load a NOP into IF/ID.
- stall_count  output  CNT_W  total stalled cycles since reset.

Behaviour:
- Source match: match_ex(rsX) = id_use_rsX && rsX != 0 && rsX == ex_rd && ex_valid && ex_reg_write. match_mem is defined the same way against mem_rd, mem_valid and mem_reg_write.
- load_hz = ex_is_load && (match_ex(rs1) || match_ex(rs2)).
- raw_hz = load_hz when FWD_EN=1. When FWD_EN=0, raw_hz = any match_ex or match_mem, regardless of ex_is_load.
- FSM states: IDLE, LSTALL. Down-counter rem has 3 bits.
- IDLE, branch_taken=1: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0. Stay in IDLE.
- IDLE, load_hz=1, no branch: pc_stall=ifid_stall=idex_bubble=1 in the same cycle (combinational). If LOAD_STALL>1, go to LSTALL with rem=LOAD_STALL-1; otherwise stay in IDLE.
- IDLE, FWD_EN=0 non-load raw_hz: same stall outputs for that cycle only. Re-evaluate every cycle; the FSM does not get involved.
- LSTALL: pc_stall=ifid_stall=idex_bubble=1 unconditionally. rem decrements each cycle; when rem==1, next state is IDLE. Hazard inputs are ignored in LSTALL.
- LSTALL, branch_taken=1: flush wins. Outputs equal the IDLE-branch case and the next state is IDLE, abandoning the stall.
- Branch always has priority over a stall in the same cycle.
- Total stall for one load-use = exactly LOAD_STALL consecutive cycles of pc_stall.
- stall_count increments by 1 on each rising edge where pc_stall=1 and saturates at 2^CNT_W-1. Wrap-around is not permitted.
- Reset (clear_n=0 at the edge): state=IDLE, rem=0, stall_count=0. While clear_n=0, all four control outputs are forced to 0 combinationally.
- Reset mid-LSTALL: the stall aborts and the block is IDLE on the next cycle.
- Register 0 never causes a hazard, even when ex_rd=0 and ex_reg_write=1.

Test Plan:
- LOAD_STALL=1, ex load rd=5, id rs2=5 with use_rs2=1 -> pc_stall/ifid_stall/idex_bubble high for exactly 1 cycle; stall_count=1.
- LOAD_STALL=3, ex load rd=7, id rs1=7 -> stalls high for 3 consecutive cycles, then low; stall_count=3. Repeat with use_rs1=0 -> no stall.
- ex load rd=0, id rs1=0 -> no stall. ex non-load rd=4, id rs1=4 with FWD_EN=1 -> no stall; with FWD_EN=0 -> 1-cycle stall. mem rd=4 with FWD_EN=0 -> stall.
- LOAD_STALL=4, branch_taken in 2nd stall cycle -> that cycle ifid_flush=1, idex_bubble=1, pc_stall=0; next cycle all low; stall_count=1.
- Simultaneous load_hz and branch_taken in IDLE -> flush only; stall_count unchanged.
- clear_n=0 mid-LSTALL -> outputs 0 immediately, stall_count=0 after the edge. CNT_W=2 with 5 stall cycles -> stall_count saturates at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : ID-stage hazard control for a five-stage pipeline. Detects RAW
//            hazards between the instruction in ID and older instructions in
//            EX/MEM, and produces the PC/IF-ID stall, ID/EX bubble and IF/ID
//            flush controls. A load-use hazard holds the pipeline for
//            LOAD_STALL cycles. A taken branch always wins over a stall.
//            stall_count is a saturating count of stalled cycles.
// Ports    : CLK, clear_n      - clock, synchronous active-low reset
//            id_rs1/2, id_use_rs1/2              - ID source operands
//            ex_valid/is_load/reg_write, ex_rd   - EX stage producer
//            mem_valid/reg_write, mem_rd         - MEM stage producer
//            branch_taken                        - taken branch resolved in EX
//            pc_stall, ifid_stall, idex_bubble, ifid_flush - pipeline controls
//            stall_count                         - saturating stalled-cycle count
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int REG_AW     = 5,
   parameter int LOAD_STALL = 1,   // 1..7
   parameter bit FWD_EN     = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic              CLK,
   input  logic              clear_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              branch_taken,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic [CNT_W-1:0]  stall_count
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LSTALL = 1'b1
   } state_t;

   // The cycle that detects the load-use hazard is the first stall cycle,
   // so LSTALL only has to cover the remaining LOAD_STALL-1 cycles.
   localparam logic [2:0]       REM_INIT = 3'(LOAD_STALL - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic ex_match_rs1, ex_match_rs2, mem_match_rs1, mem_match_rs2;
   logic load_hz, raw_hz;

   // Register 0 is hard-wired to zero and can never carry a dependency.
   always_comb begin
      ex_match_rs1  = id_use_rs1 && (id_rs1 != '0) && (id_rs1 == ex_rd)
                      && ex_valid && ex_reg_write;
      ex_match_rs2  = id_use_rs2 && (id_rs2 != '0) && (id_rs2 == ex_rd)
                      && ex_valid && ex_reg_write;
      mem_match_rs1 = id_use_rs1 && (id_rs1 != '0) && (id_rs1 == mem_rd)
                      && mem_valid && mem_reg_write;
      mem_match_rs2 = id_use_rs2 && (id_rs2 != '0) && (id_rs2 == mem_rd)
                      && mem_valid && mem_reg_write;

      load_hz = ex_is_load && (ex_match_rs1 || ex_match_rs2);

      // Without forwarding every EX/MEM producer must be waited out.
      if (FWD_EN) begin
         raw_hz = load_hz;
      end else begin
         raw_hz = ex_match_rs1 || ex_match_rs2 || mem_match_rs1 || mem_match_rs2;
      end
   end

   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      pc_stall      = 1'b0;
      ifid_stall    = 1'b0;
      idex_bubble   = 1'b0;
      ifid_flush    = 1'b0;

      if (!clear_n) begin
         state_d = IDLE;
         rem_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (load_hz) begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
                  if (LOAD_STALL > 1) begin
                     state_d = LSTALL;
                     rem_d   = REM_INIT;
                  end
               end else if (raw_hz) begin
                  // Non-load RAW without forwarding: one cycle at a time,
                  // re-evaluated every cycle.
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
               end
            end
            LSTALL: begin
               if (branch_taken) begin
                  // The stalled ID instruction is on the wrong path: drop it.
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  state_d     = IDLE;
                  rem_d       = '0;
               end else begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
                  rem_d       = rem_q - 3'd1;
                  if (rem_q == 3'd1) begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               rem_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (pc_stall && (stall_count_q != CNT_MAX)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!clear_n) begin
         state_q       <= IDLE;
         rem_q         <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule
`default_nettype wire
